// File: rtl/serial_decode_pkg.sv
// Shared types and defaults for the serial decode receiver.
package serial_decode_pkg;

    localparam int CLKS_PER_BIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/nibble_rev_inv_decode.sv
// Combinational decode: each nibble of the raw byte is bit-reversed and inverted.
module nibble_rev_inv_decode (
    input  logic [7:0] raw_in,
    output logic [7:0] dec_out
);

    always_comb begin
        dec_out = 8'h00;
        for (int i = 0; i < 4; i++) begin
            dec_out[i]     = ~raw_in[3 - i];
            dec_out[i + 4] = ~raw_in[7 - i];
        end
    end

endmodule

// File: rtl/serial_decode_rx.sv
// Serial 8N1 receiver with nibble decode; byte valid 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after line falls.
// Never stalls: a byte completing while the held byte is unconsumed is dropped with an overrun pulse.
module serial_decode_rx
    import serial_decode_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [1:0]    fill_q, fill_d;
    logic          armed_q, armed_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    raw_q, raw_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          rxs;
    logic          frame_done;
    logic          consume;
    logic [7:0]    dec_byte;

    assign rxs = sync_q[1];

    nibble_rev_inv_decode u_decode (
        .raw_in  (raw_q),
        .dec_out (dec_byte)
    );

    // fill_q marks when rxs carries a real line sample rather than the reset
    // value, so a line held low through reset can never look like a start edge.
    always_comb begin
        sync_d  = {sync_q[0], rx_serial};
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & rxs);
        prev_d  = rxs;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        raw_d       = raw_q;
        frame_done  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (armed_q && prev_q && !rxs) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    raw_d[bit_idx_q] = rxs;
                    bit_idx_d        = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    frame_done  = rxs;
                    frame_err_d = ~rxs;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completing frame may load in the same cycle the held byte is taken.
    always_comb begin
        consume      = data_valid_q & data_ready;
        data_valid_d = data_valid_q & ~consume;
        data_out_d   = data_out_q;
        overrun_d    = 1'b0;
        if (frame_done) begin
            if (!data_valid_q || consume) begin
                data_out_d   = dec_byte;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            fill_q       <= 2'b00;
            armed_q      <= 1'b0;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            raw_q        <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            raw_q        <= raw_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_serial_decode_rx.sv
// Directed bench for serial_decode_rx: frames driven on negedges, outputs sampled 1 time unit after posedge.
module tb_serial_decode_rx;

    localparam int C = 4;
    localparam int LAT = 3 + C / 2 + 9 * C;

    logic       clk;
    logic       rst_n;
    logic       rx_serial;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun_err;

    int errors = 0;
    int checks = 0;

    int         cyc = 0;
    int         start_cyc = 0;
    int         rise_at[$];
    logic [7:0] rise_dat[$];
    int         fe_cnt = 0;
    int         fe_at = 0;
    int         ov_cnt = 0;
    int         ov_at = 0;
    int         vhi_cnt = 0;
    logic       prev_v = 1'b0;

    serial_decode_rx #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_serial   (rx_serial),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event recorder: cycle stamps of valid rises and error pulses.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (data_valid) vhi_cnt++;
        if (data_valid && !prev_v) begin
            rise_at.push_back(cyc);
            rise_dat.push_back(data_out);
        end
        prev_v = data_valid;
        if (frame_err) begin
            fe_cnt++;
            fe_at = cyc;
        end
        if (overrun_err) begin
            ov_cnt++;
            ov_at = cyc;
        end
    end

    // Called at a negedge; returns at the negedge where a following start bit would begin.
    task automatic send_frame(input logic [7:0] raw, input logic stop_bit);
        start_cyc = cyc;
        rx_serial = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = raw[i];
            repeat (C) @(negedge clk);
        end
        rx_serial = stop_bit;
        repeat (C) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        rx_serial  = 1'b1;
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL reset_data_out got=%h exp=00", data_out);
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_data_valid got=%b exp=0", data_valid);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin
            errors++; $display("FAIL reset_errs got=%b%b exp=00", frame_err, overrun_err);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int n = rise_dat.size();
        int f0 = fe_cnt;
        int o0 = ov_cnt;
        int v0 = vhi_cnt;
        int s;
        data_ready = 1'b1;
        send_frame(8'h12, 1'b1);
        s = start_cyc;
        repeat (6) @(negedge clk);
        checks++;
        if (rise_dat.size() != n + 1) begin
            errors++; $display("FAIL single_count got=%0d exp=%0d", rise_dat.size() - n, 1);
        end else if (rise_dat[n] !== 8'h7B) begin
            errors++; $display("FAIL single_data got=%h exp=7B", rise_dat[n]);
        end
        checks++;
        if (rise_at.size() < n + 1 || rise_at[n] - s != LAT) begin
            errors++; $display("FAIL single_latency got=%0d exp=%0d",
                               (rise_at.size() > n) ? rise_at[n] - s : -1, LAT);
        end
        checks++;
        if (vhi_cnt - v0 != 1) begin
            errors++; $display("FAIL single_valid_width got=%0d exp=1", vhi_cnt - v0);
        end
        checks++;
        if (fe_cnt != f0 || ov_cnt != o0) begin
            errors++; $display("FAIL single_errs got=%0d/%0d exp=0/0", fe_cnt - f0, ov_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        int n = rise_dat.size();
        int f0 = fe_cnt;
        int o0 = ov_cnt;
        int v0 = vhi_cnt;
        int s2;
        data_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        s2 = start_cyc;
        repeat (6) @(negedge clk);
        checks++;
        if (rise_dat.size() != n + 2) begin
            errors++; $display("FAIL b2b_count got=%0d exp=2", rise_dat.size() - n);
        end else begin
            if (rise_dat[n] !== 8'hFF) begin
                errors++; $display("FAIL b2b_first got=%h exp=FF", rise_dat[n]);
            end
            checks++;
            if (rise_dat[n + 1] !== 8'h00) begin
                errors++; $display("FAIL b2b_second got=%h exp=00", rise_dat[n + 1]);
            end
            checks++;
            if (rise_at[n + 1] - s2 != LAT) begin
                errors++; $display("FAIL b2b_latency got=%0d exp=%0d", rise_at[n + 1] - s2, LAT);
            end
        end
        checks++;
        if (vhi_cnt - v0 != 2) begin
            errors++; $display("FAIL b2b_valid_width got=%0d exp=2", vhi_cnt - v0);
        end
        checks++;
        if (fe_cnt != f0 || ov_cnt != o0) begin
            errors++; $display("FAIL b2b_errs got=%0d/%0d exp=0/0", fe_cnt - f0, ov_cnt - o0);
        end
    endtask

    task automatic test_frame_err();
        int n = rise_dat.size();
        int f0 = fe_cnt;
        int s;
        send_frame(8'hA5, 1'b0);
        s = start_cyc;
        repeat (6) @(negedge clk);
        checks++;
        if (fe_cnt - f0 != 1) begin
            errors++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - f0);
        end
        checks++;
        if (fe_at - s != LAT) begin
            errors++; $display("FAIL ferr_timing got=%0d exp=%0d", fe_at - s, LAT);
        end
        checks++;
        if (rise_dat.size() != n || data_valid !== 1'b0) begin
            errors++; $display("FAIL ferr_no_valid got=%0d rises valid=%b exp=0 rises valid=0",
                               rise_dat.size() - n, data_valid);
        end
    endtask

    task automatic test_overrun();
        int n = rise_dat.size();
        int o0 = ov_cnt;
        int s2;
        data_ready = 1'b0;
        send_frame(8'h12, 1'b1);
        send_frame(8'h00, 1'b1);
        s2 = start_cyc;
        repeat (6) @(negedge clk);
        checks++;
        if (data_out !== 8'h7B || data_valid !== 1'b1) begin
            errors++; $display("FAIL ovr_held got=%h/%b exp=7B/1", data_out, data_valid);
        end
        checks++;
        if (rise_dat.size() != n + 1) begin
            errors++; $display("FAIL ovr_rises got=%0d exp=1", rise_dat.size() - n);
        end
        checks++;
        if (ov_cnt - o0 != 1) begin
            errors++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt - o0);
        end
        checks++;
        if (ov_at - s2 != LAT) begin
            errors++; $display("FAIL ovr_timing got=%0d exp=%0d", ov_at - s2, LAT);
        end
        data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0 || data_out !== 8'h7B) begin
            errors++; $display("FAIL ovr_consume got=%h/%b exp=7B/0", data_out, data_valid);
        end
    endtask

    task automatic test_handshake_load();
        int n = rise_dat.size();
        int o0 = ov_cnt;
        data_ready = 1'b0;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h00) begin
            errors++; $display("FAIL hs_load got=%h/%b exp=00/1", data_out, data_valid);
        end
        checks++;
        if (ov_cnt != o0 || rise_dat.size() != n + 1) begin
            errors++; $display("FAIL hs_no_overrun got=%0d ovr %0d rises exp=0 ovr 1 rise",
                               ov_cnt - o0, rise_dat.size() - n);
        end
        data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++; $display("FAIL hs_drain got=%b exp=0", data_valid);
        end
    endtask

    task automatic test_glitch();
        int n = rise_dat.size();
        int f0 = fe_cnt;
        int o0 = ov_cnt;
        rx_serial = 1'b0;
        @(negedge clk);
        rx_serial = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (rise_dat.size() != n || fe_cnt != f0 || ov_cnt != o0) begin
            errors++; $display("FAIL glitch_quiet got=%0d rises %0d ferr %0d ovr exp=0 0 0",
                               rise_dat.size() - n, fe_cnt - f0, ov_cnt - o0);
        end
        send_frame(8'h12, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (rise_dat.size() != n + 1 || data_out !== 8'h7B) begin
            errors++; $display("FAIL glitch_recover got=%0d rises data=%h exp=1 rise data=7B",
                               rise_dat.size() - n, data_out);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] raw = 8'hFF;
        int n;
        int f0;
        int o0;
        data_ready = 1'b1;
        rx_serial = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_serial = raw[i];
            repeat (C) @(negedge clk);
        end
        rx_serial = raw[4];
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_async got=%h/%b exp=00/0", data_out, data_valid);
        end
        n  = rise_dat.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h12, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (rise_dat.size() != n + 1) begin
            errors++; $display("FAIL midrst_count got=%0d exp=1", rise_dat.size() - n);
        end else if (rise_dat[n] !== 8'h7B) begin
            errors++; $display("FAIL midrst_data got=%h exp=7B", rise_dat[n]);
        end
        checks++;
        if (fe_cnt != f0 || ov_cnt != o0) begin
            errors++; $display("FAIL midrst_errs got=%0d/%0d exp=0/0", fe_cnt - f0, ov_cnt - o0);
        end
    endtask

    task automatic test_low_at_reset();
        int n;
        int f0;
        rst_n = 1'b0;
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        n  = rise_dat.size();
        f0 = fe_cnt;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (rise_dat.size() != n || fe_cnt != f0) begin
            errors++; $display("FAIL lowrst_quiet got=%0d rises %0d ferr exp=0 0",
                               rise_dat.size() - n, fe_cnt - f0);
        end
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h12, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (rise_dat.size() != n + 1 || data_out !== 8'h7B) begin
            errors++; $display("FAIL lowrst_frame got=%0d rises data=%h exp=1 rise data=7B",
                               rise_dat.size() - n, data_out);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_serial  = 1'b1;
        data_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_overrun();
        test_handshake_load();
        test_glitch();
        test_mid_reset();
        test_low_at_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_decode_rx.md
SERIAL_DECODE_RX -- requirements
Module: serial_decode_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit; it SHALL be an even integer of at least 4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port rx_serial, input, 1 bit: the asynchronous serial line, idle high.
REQ-005 The module SHALL have port data_out, output, 8 bits: the decoded byte.
REQ-006 The module SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed byte.
REQ-007 The module SHALL have port data_ready, input, 1 bit: the consumer accepts the byte.
REQ-008 The module SHALL have port frame_err, output, 1 bit: a 1-cycle pulse when a stop bit is sampled as 0.
REQ-009 The module SHALL have port overrun_err, output, 1 bit: a 1-cycle pulse when a completed byte is dropped.

Function
REQ-010 rx_serial SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value rxs.
REQ-011 The frame format SHALL be: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-012 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-013 In IDLE, a falling edge on rxs (previous value 1, current value 0) SHALL move the FSM to START and clear the baud counter.
REQ-014 In START, at count CLKS_PER_BIT/2-1 (mid-bit), rxs=0 SHALL move the FSM to DATA, and rxs=1 SHALL return it to IDLE as a glitch, with no output.
REQ-015 In DATA, the module SHALL sample rxs every CLKS_PER_BIT cycles after the mid-start point into raw[bit_idx], where bit_idx runs 0..7; after bit 7 the FSM SHALL move to STOP.
REQ-016 In STOP, one CLKS_PER_BIT later, rxs=1 SHALL complete the frame, and rxs=0 SHALL discard the byte and pulse frame_err; in both cases the FSM SHALL then return to IDLE.
REQ-017 Decode: data_out[i] SHALL equal ~raw[3-i] for i=0..3, and ~raw[11-i] for i=4..7, i.e. each nibble is bit-reversed and inverted.
REQ-018 On a completed frame, the decoded byte SHALL load into the output register and data_valid SHALL assert on the next clock edge.
REQ-019 Latency: from the first cycle rx_serial is low, data_valid SHALL rise after exactly 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (41 cycles at the default).
REQ-020 Handshake: when data_valid and data_ready are both 1 at a clock edge, the byte is consumed and data_valid SHALL drop unless a new byte loads in that same cycle.
REQ-021 data_out SHALL remain stable while data_valid=1 and not consumed.
REQ-022 If a frame completes while data_valid=1 and data_ready=0, the new byte SHALL be dropped, the held byte kept, and overrun_err pulsed.
REQ-023 If a frame completes in the same cycle that a handshake occurs, the new byte SHALL load, data_valid SHALL stay 1, and there SHALL be no overrun.
REQ-024 The receiver SHALL keep receiving while data_valid=1; backpressure SHALL never stall the FSM.
REQ-025 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit_idx SHALL be 3 bits wide and reset on each new frame.

Reset
REQ-026 Asserting rst_n=0 SHALL at once set the FSM to IDLE, both synchronizer flops and the previous-rxs register to 1, counters to 0, data_out to 0x00, and data_valid, frame_err and overrun_err to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output and no error pulse.
REQ-028 After rst_n deasserts, a line that is already low SHALL NOT start a frame until a falling edge is seen.

Structure
REQ-029 A shared package serial_decode_pkg SHALL hold the state enum (IDLE, START, DATA, STOP) and the default CLKS_PER_BIT constant.
REQ-030 The nibble-reverse-invert mapping SHALL be a combinational sub-module, nibble_rev_inv_decode (8 bits in, 8 bits out), instantiated once.

Verification
REQ-031 Send frame raw 0x12 with data_ready=1 -> data_out=0x7B; data_valid high 1 cycle, 41 cycles after the start edge.
REQ-032 Send raw 0x00, then raw 0xFF, back-to-back with data_ready=1 -> data_out=0xFF, then data_out=0x00; no error pulses.
REQ-033 Send raw 0xA5 with stop bit forced to 0 -> frame_err pulses once, data_valid stays 0.
REQ-034 Hold data_ready=0; send raw 0x12, then raw 0x00 -> data_out stays 0x7B, overrun_err pulses once at the second frame's end; raising data_ready consumes 0x7B.
REQ-035 Give rx_serial a low glitch of 1 cycle (shorter than CLKS_PER_BIT/2) -> FSM returns to IDLE; no data_valid or error.
REQ-036 Drop rst_n during DATA bit 4 of a frame, then release it and send raw 0x12 -> no output from the aborted frame; next output is 0x7B.
